adder32_accumulator: RTL and testbench
======================================

# adder32_accumulator

Sequential accumulation stage directly downstream of the 32-bit adder. It consumes the adder's (nb_bits+1)-bit sum words through a valid/ready handshake and accumulates a programmable number of them into a widened, overflow-free total. The total is presented on a held-valid output port. The block converts the adder's single-shot combinational result into a framed, flow-controlled multi-sample sum for downstream consumers.

## Interface
Parameters:
- nb_bits, 32, operand width of the upstream adder; sum words are nb_bits+1 bits.
- max_samples, 16, maximum samples per accumulation frame; must be ≥ 1.
- Derived, not overridable:
  - acc_bits = nb_bits+1+$clog2(max_samples)
  - len_bits = $clog2(max_samples+1)

Ports:
- clk_i  input  1  single clock, rising edge.
- rst_i  input  1  reset, asynchronous and active-high.
- start_i  input  1  frame start request; sampled only in IDLE.
- len_i  input  len_bits  number of samples for the frame; captured with start_i.
- sum_i  input  nb_bits+1  sum word from the adder, zero-extended on accumulate.
- sum_valid_i  input  1  sum_i is valid.
- sum_ready_o  output  1  block accepts a sum word this cycle.
- acc_o  output  acc_bits  accumulated total.
- acc_valid_o  output  1  acc_o holds a completed frame result.
- acc_ready_i  input  1  downstream consumes acc_o.
- busy_o  output  1  high in ACCUM and DONE.
- count_o  output  len_bits  samples accepted so far in the current frame.

## Operation
- FSM states: IDLE, ACCUM, DONE.
- **IDLE**
  - start_i=1 → capture target = min(len_i, max_samples), clear accumulator and count.
  - If target = 0, go to DONE; otherwise go to ACCUM.
- **ACCUM**
  - sum_ready_o=1.
  - Each handshake (sum_valid_i & sum_ready_o) does acc += zero-extend(sum_i) and count += 1.
  - The handshake that makes count equal target goes to DONE.
- **DONE**
  - acc_valid_o=1; acc_o and count_o are held stable.
  - acc_ready_i=1 → IDLE.
- start_i outside IDLE is ignored, including start_i coincident with acc_ready_i in DONE; it must be re-issued in IDLE.
- sum_valid_i outside ACCUM is ignored; sum_ready_o=0 there.
- Arithmetic: acc_bits is sized so max_samples × (2^(nb_bits+1)−2) never overflows. No saturation or overflow flag exists.
- Reset values: sum_ready_o=0, acc_valid_o=0, busy_o=0, acc_o=0, count_o=0, state=IDLE.
- Reset asserted mid-frame clears everything immediately (asynchronous) and discards the partial sum.

## Timing
- start_i accepted at edge N → sum_ready_o high from cycle N+1 (ACCUM), or acc_valid_o high from N+1 when target=0.
- Throughput: one sum word per cycle while sum_valid_i is held high.
- Latency: final handshake at edge M → acc_valid_o and the final acc_o are visible from cycle M+1.
- Frame length equals target handshakes; a back-to-back frame has a minimum 1 IDLE cycle between the DONE handshake and the next start.
- sum_ready_o is a registered, state-derived signal with no combinational path from sum_valid_i.
- acc_valid_o remains high until acc_ready_i=1. It deasserts the cycle after that handshake.

## Structure
- Shared package adder32_pkg holds:
  - typedef enum logic [1:0] acc_state_t {IDLE, ACCUM, DONE};
  - localparam helpers computing acc_bits and len_bits from nb_bits and max_samples.
- The accumulator is an inline registered add.
- One sub-module, frame_counter: loadable target register, up-counter, and terminal-count compare (count+1 == target on handshake).

## Test plan
- nb_bits=32, max_samples=16: start with len_i=4, sums 1,2,3,4 on consecutive cycles → acc_o=10 and acc_valid_o=1 the cycle after the 4th handshake, count_o=4.
- len_i=16, every sum_i=0x1_FFFF_FFFE → acc_o=0x1F_FFFF_FFE0, no wrap.
- len_i=0 → DONE one cycle after start, acc_o=0, sum_ready_o never asserted.
- len_i=20 → clamped to 16:
  - exactly 16 handshakes accepted;
  - 17th sum_valid_i sees sum_ready_o=0;
  - count_o=16.
- Hold acc_ready_i=0 for 5 cycles in DONE, with sum_valid_i pulses and start_i=1 during that time:
  - acc_o and acc_valid_o stay stable;
  - the pulses are ignored;
  - IDLE is entered only after acc_ready_i=1.
- rst_i pulsed asynchronously after 2 of 4 samples → all outputs 0 immediately. Then start with len_i=1 and sum 7 → acc_o=7.

Source files
------------

// File: rtl/adder32_pkg.sv
// Shared types and width helpers for the adder32 accumulation stage.
package adder32_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_t;

  // Wide enough that max_samples * (2^(nb_bits+1)-2) cannot wrap.
  function automatic int calc_acc_bits(input int nb_bits, input int max_samples);
    return nb_bits + 1 + $clog2(max_samples);
  endfunction

  function automatic int calc_len_bits(input int max_samples);
    return $clog2(max_samples + 1);
  endfunction

endpackage

// File: rtl/frame_counter.sv
// Frame length tracking: clamped target register, sample up-counter and
// terminal-count detect for the handshake that completes the frame.
module frame_counter
  import adder32_pkg::*;
#(
  parameter int max_samples = 16,
  parameter int len_bits    = calc_len_bits(max_samples)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic [len_bits-1:0] len_i,
  input  logic                inc_i,
  output logic [len_bits-1:0] count_o,
  output logic                target_zero_o,
  output logic                last_o
);

  localparam logic [len_bits-1:0] max_len = len_bits'(max_samples);

  logic [len_bits-1:0] target_q;
  logic [len_bits-1:0] count_q;
  logic [len_bits-1:0] target_d;

  assign target_d = (len_i > max_len) ? max_len : len_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      target_q <= '0;
      count_q  <= '0;
    end else if (load_i) begin
      target_q <= target_d;
      count_q  <= '0;
    end else if (inc_i) begin
      count_q <= count_q + len_bits'(1);
    end
  end

  // Evaluated against the incoming length so a zero-length frame can skip ACCUM.
  assign target_zero_o = (len_i == '0);
  assign last_o        = inc_i && ((count_q + len_bits'(1)) == target_q);
  assign count_o       = count_q;

endmodule

// File: rtl/adder32_accumulator.sv
// Accumulates a programmable number of adder sum words into a widened total.
// Handshakes: a word moves on sum_valid_i & sum_ready_o at a rising edge; the
// result moves on acc_valid_o & acc_ready_i; valid never waits on ready.
module adder32_accumulator
  import adder32_pkg::*;
#(
  parameter  int nb_bits     = 32,
  parameter  int max_samples = 16,
  localparam int acc_bits    = calc_acc_bits(nb_bits, max_samples),
  localparam int len_bits    = calc_len_bits(max_samples)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [len_bits-1:0] len_i,
  input  logic [nb_bits:0]    sum_i,
  input  logic                sum_valid_i,
  output logic                sum_ready_o,
  output logic [acc_bits-1:0] acc_o,
  output logic                acc_valid_o,
  input  logic                acc_ready_i,
  output logic                busy_o,
  output logic [len_bits-1:0] count_o,
  output acc_state_t          state_o
);

  acc_state_t          state_q;
  acc_state_t          state_d;
  logic [acc_bits-1:0] acc_q;
  logic                load;
  logic                accept;
  logic                target_zero;
  logic                last;

  assign load   = (state_q == IDLE) && start_i;
  assign accept = sum_valid_i && sum_ready_o;

  frame_counter #(
    .max_samples (max_samples),
    .len_bits    (len_bits)
  ) u_frame_counter (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .load_i        (load),
    .len_i         (len_i),
    .inc_i         (accept),
    .count_o       (count_o),
    .target_zero_o (target_zero),
    .last_o        (last)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i)     state_d = target_zero ? DONE : ACCUM;
      ACCUM:   if (last)        state_d = DONE;
      DONE:    if (acc_ready_i) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  always_comb begin
    sum_ready_o = 1'b0;
    acc_valid_o = 1'b0;
    busy_o      = 1'b0;
    unique case (state_q)
      ACCUM: begin
        sum_ready_o = 1'b1;
        busy_o      = 1'b1;
      end
      DONE: begin
        acc_valid_o = 1'b1;
        busy_o      = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else if (load) begin
      acc_q <= '0;
    end else if (accept) begin
      acc_q <= acc_q + acc_bits'(sum_i);
    end
  end

  assign acc_o   = acc_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_adder32_accumulator.sv
// Directed bench for adder32_accumulator (nb_bits=32, max_samples=16).
module tb_adder32_accumulator;
  import adder32_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [4:0]  len;
  logic [32:0] sum;
  logic        sum_valid;
  logic        sum_ready;
  logic [36:0] acc;
  logic        acc_valid;
  logic        acc_ready;
  logic        busy;
  logic [4:0]  count;
  acc_state_t  state;

  int checks   = 0;
  int failures = 0;

  adder32_accumulator #(
    .nb_bits     (32),
    .max_samples (16)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .len_i       (len),
    .sum_i       (sum),
    .sum_valid_i (sum_valid),
    .sum_ready_o (sum_ready),
    .acc_o       (acc),
    .acc_valid_o (acc_valid),
    .acc_ready_i (acc_ready),
    .busy_o      (busy),
    .count_o     (count),
    .state_o     (state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [4:0] n);
    start = 1'b1;
    len   = n;
    step();
    start = 1'b0;
  endtask

  task automatic consume();
    acc_ready = 1'b1;
    step();
    acc_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; len = '0; sum = '0; sum_valid = 1'b0; acc_ready = 1'b0;
    #12;
    checks++;
    if ({sum_ready, acc_valid, busy} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=000", {sum_ready, acc_valid, busy});
    end
    checks++;
    if (acc !== 37'd0 || count !== 5'd0 || state !== IDLE) begin
      failures++;
      $display("FAIL reset_regs acc=%0h count=%0d state=%0d exp 0/0/IDLE", acc, count, state);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    start_frame(5'd4);
    checks++;
    if (sum_ready !== 1'b1 || busy !== 1'b1 || count !== 5'd0) begin
      failures++;
      $display("FAIL basic_enter ready=%b busy=%b count=%0d exp 1/1/0", sum_ready, busy, count);
    end
    for (int i = 1; i <= 4; i++) begin
      sum = 33'(i);
      sum_valid = 1'b1;
      step();
      if (i == 3) begin
        checks++;
        if (acc_valid !== 1'b0 || acc !== 37'd6) begin
          failures++;
          $display("FAIL basic_partial valid=%b acc=%0d exp 0/6", acc_valid, acc);
        end
      end
    end
    sum_valid = 1'b0;
    checks++;
    if (acc_valid !== 1'b1 || acc !== 37'd10 || count !== 5'd4 || sum_ready !== 1'b0) begin
      failures++;
      $display("FAIL basic_done valid=%b acc=%0d count=%0d ready=%b exp 1/10/4/0",
               acc_valid, acc, count, sum_ready);
    end
    consume();
    checks++;
    if (acc_valid !== 1'b0 || busy !== 1'b0 || state !== IDLE) begin
      failures++;
      $display("FAIL basic_release valid=%b busy=%b state=%0d exp 0/0/IDLE", acc_valid, busy, state);
    end
  endtask

  task automatic test_max_value();
    start_frame(5'd16);
    sum = 33'h1_FFFF_FFFE;
    sum_valid = 1'b1;
    repeat (16) step();
    sum_valid = 1'b0;
    checks++;
    if (acc !== 37'h1F_FFFF_FFE0 || acc_valid !== 1'b1 || count !== 5'd16) begin
      failures++;
      $display("FAIL max_value acc=%0h valid=%b count=%0d exp 1fffffffe0/1/16", acc, acc_valid, count);
    end
    consume();
  endtask

  task automatic test_zero_len();
    int ready_seen = 0;
    sum_valid = 1'b1;
    sum = 33'd55;
    start_frame(5'd0);
    if (sum_ready) ready_seen++;
    checks++;
    if (acc_valid !== 1'b1 || acc !== 37'd0 || count !== 5'd0 || state !== DONE) begin
      failures++;
      $display("FAIL zero_len valid=%b acc=%0d count=%0d state=%0d exp 1/0/0/DONE",
               acc_valid, acc, count, state);
    end
    repeat (2) begin
      step();
      if (sum_ready) ready_seen++;
    end
    sum_valid = 1'b0;
    checks++;
    if (ready_seen != 0 || acc !== 37'd0) begin
      failures++;
      $display("FAIL zero_len_ready ready_cycles=%0d acc=%0d exp 0/0", ready_seen, acc);
    end
    consume();
  endtask

  task automatic test_clamp();
    int hs = 0;
    start_frame(5'd20);
    sum = 33'd1;
    sum_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      if (i == 16) begin
        checks++;
        if (sum_ready !== 1'b0) begin
          failures++;
          $display("FAIL clamp_17th ready=%b exp 0", sum_ready);
        end
      end
      if (sum_ready) hs++;
      step();
    end
    sum_valid = 1'b0;
    checks++;
    if (hs != 16 || count !== 5'd16 || acc !== 37'd16 || acc_valid !== 1'b1) begin
      failures++;
      $display("FAIL clamp hs=%0d count=%0d acc=%0d valid=%b exp 16/16/16/1", hs, count, acc, acc_valid);
    end
    consume();
  endtask

  task automatic test_hold_done();
    int bad = 0;
    start_frame(5'd2);
    sum_valid = 1'b1;
    sum = 33'd5; step();
    sum = 33'd6; step();
    for (int i = 0; i < 5; i++) begin
      sum_valid = i[0];
      sum       = 33'd100;
      start     = 1'b1;
      len       = 5'd3;
      step();
      if (acc !== 37'd11 || acc_valid !== 1'b1 || count !== 5'd2 || state !== DONE) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL hold_done unstable_cycles=%0d acc=%0d valid=%b exp 0 (acc 11 valid 1)",
               bad, acc, acc_valid);
    end
    // start coincident with the release handshake must be dropped
    sum_valid = 1'b0;
    acc_ready = 1'b1;
    step();
    start = 1'b0;
    acc_ready = 1'b0;
    checks++;
    if (state !== IDLE || acc_valid !== 1'b0 || sum_ready !== 1'b0) begin
      failures++;
      $display("FAIL hold_release state=%0d valid=%b ready=%b exp IDLE/0/0", state, acc_valid, sum_ready);
    end
    step();
    checks++;
    if (state !== IDLE || busy !== 1'b0) begin
      failures++;
      $display("FAIL hold_start_ignored state=%0d busy=%b exp IDLE/0", state, busy);
    end
  endtask

  task automatic test_async_reset();
    start_frame(5'd4);
    sum_valid = 1'b1;
    sum = 33'd1; step();
    sum = 33'd2; step();
    sum = 33'd3;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({sum_ready, acc_valid, busy} !== 3'b000 || acc !== 37'd0 || count !== 5'd0 || state !== IDLE) begin
      failures++;
      $display("FAIL async_reset ready=%b valid=%b busy=%b acc=%0d count=%0d exp all 0",
               sum_ready, acc_valid, busy, acc, count);
    end
    sum_valid = 1'b0;
    #1 rst = 1'b0;
    step();
    start_frame(5'd1);
    sum = 33'd7;
    sum_valid = 1'b1;
    step();
    sum_valid = 1'b0;
    checks++;
    if (acc !== 37'd7 || acc_valid !== 1'b1 || count !== 5'd1) begin
      failures++;
      $display("FAIL after_reset acc=%0d valid=%b count=%0d exp 7/1/1", acc, acc_valid, count);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    start_frame(5'd1);
    sum = 33'd9; sum_valid = 1'b1; step(); sum_valid = 1'b0;
    checks++;
    if (acc !== 37'd9 || acc_valid !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first acc=%0d valid=%b exp 9/1", acc, acc_valid);
    end
    consume();
    start_frame(5'd2);
    checks++;
    if (acc !== 37'd0 || sum_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_clear acc=%0d ready=%b exp 0/1", acc, sum_ready);
    end
    sum_valid = 1'b1;
    sum = 33'd3; step();
    sum_valid = 1'b0; step();
    sum_valid = 1'b1;
    sum = 33'd4; step();
    sum_valid = 1'b0;
    checks++;
    if (acc !== 37'd7 || acc_valid !== 1'b1 || count !== 5'd2) begin
      failures++;
      $display("FAIL b2b_second acc=%0d valid=%b count=%0d exp 7/1/2", acc, acc_valid, count);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max_value();
    test_zero_len();
    test_clamp();
    test_hold_done();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout sim_time=%0t limit=20000", $time);
    $fatal(1, "timeout");
  end

endmodule
